tse_tx_arbiter: RTL and testbench



---
 rtl/tse_tx_arb_pkg.sv | 28 ++
 rtl/rr_pick.sv | 31 +++
 rtl/tse_tx_arbiter.sv | 178 +++++++++++++++++
 tb/tb_tse_tx_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tse_tx_arb_pkg.sv
// Shared types and sizing for the TSE transmit arbiter.
//   AST_DATA_W / AST_EMPTY_W : Avalon-ST payload widths of the MAC transmit port
//   ast_beat_t               : one Avalon-ST beat payload (data, empty, sop, eop)
//   arb_state_e              : arbiter FSM states
//   beat_cnt_w()             : width needed to count 0..max_beats
package tse_tx_arb_pkg;

  localparam int unsigned AST_DATA_W  = 32;
  localparam int unsigned AST_EMPTY_W = 2;

  typedef struct packed {
    logic [AST_DATA_W-1:0]  data;
    logic [AST_EMPTY_W-1:0] empty;
    logic                   sop;
    logic                   eop;
  } ast_beat_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  function automatic int unsigned beat_cnt_w(input int unsigned max_beats);
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req        : request vector
//   last_grant : index of the most recent winner; search starts at last_grant+1
//   pick       : one-hot winner, all zero when no request
module rr_pick #(
  parameter  int unsigned NUM_SRC = 2,
  localparam int unsigned IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_SRC-1:0] pick
);

  logic             found;
  logic [IDX_W-1:0] idx;

  // Walk the sources in rotated order and keep the first requester.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      idx = IDX_W'((32'(last_grant) + k) % NUM_SRC);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tse_tx_arbiter.sv
// Packet-atomic round-robin arbiter onto the TSE MAC Avalon-ST transmit port.
//   clk_sys_125_clk / reset_sys_125_reset : 125 MHz clock, async active-high reset
//   src_*        : NUM_SRC generator streams (data/empty packed per source)
//   tx_*         : MAC transmit port; data path is combinational from the owner
//   grant        : one-hot owner, zero while idle
//   tx_pkt_count : packets ended on tx (wraps); trunc_count : truncations (saturates)
module tse_tx_arbiter
  import tse_tx_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC   = 2,
  parameter int unsigned MAX_BEATS = 380
) (
  input  logic                           clk_sys_125_clk,
  input  logic                           reset_sys_125_reset,
  input  logic [NUM_SRC-1:0]             src_enable,
  input  logic [NUM_SRC*AST_DATA_W-1:0]  src_data,
  input  logic [NUM_SRC*AST_EMPTY_W-1:0] src_empty,
  input  logic [NUM_SRC-1:0]             src_sop,
  input  logic [NUM_SRC-1:0]             src_eop,
  input  logic [NUM_SRC-1:0]             src_valid,
  output logic [NUM_SRC-1:0]             src_ready,
  output logic [AST_DATA_W-1:0]          tx_data,
  output logic [AST_EMPTY_W-1:0]         tx_empty,
  output logic                           tx_sop,
  output logic                           tx_eop,
  output logic                           tx_valid,
  output logic                           tx_error,
  input  logic                           tx_ready,
  output logic [NUM_SRC-1:0]             grant,
  output logic [31:0]                    tx_pkt_count,
  output logic [15:0]                    trunc_count
);

  localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned BC_W  = beat_cnt_w(MAX_BEATS);

  arb_state_e         state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [BC_W-1:0]    beat_q, beat_d;
  logic [31:0]        pkt_q, pkt_d;
  logic [15:0]        trunc_q, trunc_d;

  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] pick;
  logic [IDX_W-1:0]   pick_idx;
  ast_beat_t          sel;
  logic               sel_valid;
  logic               trunc;
  logic               accept;

  assign req          = src_valid & src_sop & src_enable;
  assign grant        = grant_q;
  assign tx_pkt_count = pkt_q;
  assign trunc_count  = trunc_q;

  rr_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_rr_pick (
    .req        (req),
    .last_grant (last_q),
    .pick       (pick)
  );

  // Owner beat mux and one-hot-to-index encode of the picker result.
  always_comb begin
    sel       = '0;
    sel_valid = 1'b0;
    pick_idx  = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (owner_q == IDX_W'(i)) begin
        sel.data  = src_data[i*AST_DATA_W +: AST_DATA_W];
        sel.empty = src_empty[i*AST_EMPTY_W +: AST_EMPTY_W];
        sel.sop   = src_sop[i];
        sel.eop   = src_eop[i];
        sel_valid = src_valid[i];
      end
      if (pick[i]) pick_idx = IDX_W'(i);
    end
  end

  // Next-state, counters and port drive.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    last_d    = last_q;
    beat_d    = beat_q;
    pkt_d     = pkt_q;
    trunc_d   = trunc_q;
    src_ready = '0;
    tx_valid  = 1'b0;
    tx_data   = '0;
    tx_empty  = '0;
    tx_sop    = 1'b0;
    tx_eop    = 1'b0;
    tx_error  = 1'b0;
    trunc     = 1'b0;
    accept    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = SEND;
          grant_d = pick;
          owner_d = pick_idx;
          beat_d  = '0;
        end
      end

      SEND: begin
        // An eop landing on the last allowed beat is a clean end, not a truncation.
        trunc     = (beat_q == BC_W'(MAX_BEATS - 1)) && !sel.eop;
        src_ready = grant_q & {NUM_SRC{tx_ready}};
        if (sel_valid) begin
          tx_valid = 1'b1;
          tx_data  = sel.data;
          tx_sop   = sel.sop;
          tx_eop   = sel.eop | trunc;
          tx_error = trunc;
          tx_empty = trunc ? '0 : sel.empty;
        end
        accept = sel_valid & tx_ready;
        if (accept) begin
          beat_d = beat_q + BC_W'(1);
          if (tx_eop) begin
            last_d = owner_q;
            pkt_d  = pkt_q + 32'd1;
            if (trunc) begin
              if (trunc_q != 16'hFFFF) trunc_d = trunc_q + 16'd1;
              state_d = DRAIN;
            end else begin
              state_d = IDLE;
              grant_d = '0;
            end
          end
        end
      end

      DRAIN: begin
        // Swallow the tail of a truncated packet; MAC sees nothing.
        src_ready = grant_q;
        if (sel_valid && sel.eop) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk_sys_125_clk or posedge reset_sys_125_reset) begin
    if (reset_sys_125_reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= IDX_W'(NUM_SRC - 1);
      beat_q  <= '0;
      pkt_q   <= '0;
      trunc_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      pkt_q   <= pkt_d;
      trunc_q <= trunc_d;
    end
  end

endmodule

// File: tb/tb_tse_tx_arbiter.sv
// Directed bench for tse_tx_arbiter (NUM_SRC=2, MAX_BEATS=4): source beat
// queues drive the inputs, expected tx beats go to a scoreboard queue.
module tb_tse_tx_arbiter;

  localparam int MAXB = 4;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  empty;
    logic        sop;
    logic        eop;
  } sbeat_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  empty;
    logic        sop;
    logic        eop;
    logic        err;
  } tbeat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  src_enable;
  logic [63:0] src_data;
  logic [3:0]  src_empty;
  logic [1:0]  src_sop, src_eop, src_valid, src_ready;
  logic [31:0] tx_data;
  logic [1:0]  tx_empty;
  logic        tx_sop, tx_eop, tx_valid, tx_error, tx_ready;
  logic [1:0]  grant;
  logic [31:0] tx_pkt_count;
  logic [15:0] trunc_count;

  sbeat_t q0[$];
  sbeat_t q1[$];
  tbeat_t sb[$];

  int compared   = 0;
  int mismatched = 0;
  int exp_pkts   = 0;
  int drained    = 0;

  logic       obs_tx_valid;
  logic       obs_drain;
  logic [1:0] obs_grant;
  logic [1:0] obs_src_ready;

  always #5 clk = ~clk;

  tse_tx_arbiter #(
    .NUM_SRC   (2),
    .MAX_BEATS (MAXB)
  ) dut (
    .clk_sys_125_clk     (clk),
    .reset_sys_125_reset (rst),
    .src_enable          (src_enable),
    .src_data            (src_data),
    .src_empty           (src_empty),
    .src_sop             (src_sop),
    .src_eop             (src_eop),
    .src_valid           (src_valid),
    .src_ready           (src_ready),
    .tx_data             (tx_data),
    .tx_empty            (tx_empty),
    .tx_sop              (tx_sop),
    .tx_eop              (tx_eop),
    .tx_valid            (tx_valid),
    .tx_error            (tx_error),
    .tx_ready            (tx_ready),
    .grant               (grant),
    .tx_pkt_count        (tx_pkt_count),
    .trunc_count         (trunc_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue one packet on a source and the tx beats it must produce.
  task automatic send_pkt(input int src, input int n, input logic [1:0] last_empty,
                          input logic [1:0] mid_empty, input int pid);
    sbeat_t b;
    tbeat_t t;
    for (int i = 0; i < n; i++) begin
      b.data  = {8'hA0 + 8'(src), 8'(pid), 16'(i)};
      b.sop   = (i == 0);
      b.eop   = (i == n - 1);
      b.empty = b.eop ? last_empty : mid_empty;
      if (src == 0) q0.push_back(b);
      else          q1.push_back(b);
      if (i < MAXB) begin
        t.data  = b.data;
        t.sop   = b.sop;
        t.err   = (i == MAXB - 1) && !b.eop;
        t.eop   = b.eop || t.err;
        t.empty = t.err ? 2'd0 : b.empty;
        sb.push_back(t);
      end
    end
    exp_pkts++;
  endtask

  task automatic drive_inputs();
    src_valid = {q1.size() != 0, q0.size() != 0};
    src_data  = '0;
    src_empty = '0;
    src_sop   = '0;
    src_eop   = '0;
    if (q0.size() != 0) begin
      src_data[31:0] = q0[0].data;
      src_empty[1:0] = q0[0].empty;
      src_sop[0]     = q0[0].sop;
      src_eop[0]     = q0[0].eop;
    end
    if (q1.size() != 0) begin
      src_data[63:32] = q1[0].data;
      src_empty[3:2]  = q1[0].empty;
      src_sop[1]      = q1[0].sop;
      src_eop[1]      = q1[0].eop;
    end
  endtask

  // One clock: drive at negedge, sample 1 ns later, retire handshakes at posedge.
  task automatic cycle();
    logic [1:0] pop;
    tbeat_t     got;
    tbeat_t     exp;
    sbeat_t     tmp;
    drive_inputs();
    #1;
    obs_tx_valid  = tx_valid;
    obs_grant     = grant;
    obs_src_ready = src_ready;
    pop           = src_valid & src_ready;
    obs_drain     = (pop != 2'b00) && !tx_valid;
    if (obs_drain) drained++;
    if (tx_valid && tx_ready) begin
      got = {tx_data, tx_empty, tx_sop, tx_eop, tx_error};
      compared++;
      assert (sb.size() != 0) else begin
        mismatched++;
        $error("FAIL tx_unexpected_beat observed=%0h expected=none", got);
      end
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        chk("tx_beat", 64'(got), 64'(exp));
      end
    end
    @(posedge clk);
    if (pop[0] && q0.size() != 0) tmp = q0.pop_front();
    if (pop[1] && q1.size() != 0) tmp = q1.pop_front();
    @(negedge clk);
  endtask

  task automatic run_until_empty(input int budget, input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || q0.size() != 0 || q1.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    compared++;
    assert (sb.size() == 0 && q0.size() == 0 && q1.size() == 0) else begin
      mismatched++;
      $error("FAIL %s_timeout observed=%0d_left expected=0", tag,
             sb.size() + q0.size() + q1.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] pat;
    int          k;

    rst        = 1'b1;
    src_enable = 2'b11;
    tx_ready   = 1'b1;
    drive_inputs();
    @(negedge clk);
    chk("rst_tx_valid",  64'(tx_valid),     64'd0);
    chk("rst_src_ready", 64'(src_ready),    64'd0);
    chk("rst_grant",     64'(grant),        64'd0);
    chk("rst_pkt_count", 64'(tx_pkt_count), 64'd0);
    chk("rst_trunc",     64'(trunc_count),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: single 3-beat packet, empty=2 on eop; one arbitration cycle first.
    send_pkt(0, 3, 2'd2, 2'd0, 1);
    cycle();
    chk("t1_idle_valid", 64'(obs_tx_valid), 64'd0);
    chk("t1_idle_grant", 64'(obs_grant),    64'd0);
    cycle();
    chk("t1_first_valid", 64'(obs_tx_valid), 64'd1);
    chk("t1_first_grant", 64'(obs_grant),    64'b01);
    run_until_empty(20, "t1");
    chk("t1_pkt_count", 64'(tx_pkt_count), 64'(exp_pkts));
    chk("t1_grant_idle", 64'(grant), 64'd0);

    // 2: both request; source 0 just won, so source 1 goes first, then alternate.
    send_pkt(1, 2, 2'd1, 2'd0, 2);
    send_pkt(0, 2, 2'd0, 2'd0, 3);
    send_pkt(1, 2, 2'd3, 2'd0, 4);
    send_pkt(0, 2, 2'd2, 2'd0, 5);
    pat = '0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      pat = {pat[10:0], obs_tx_valid};
    end
    chk("t2_bubble_pattern", 64'(pat), 64'(12'b011011011011));
    run_until_empty(20, "t2");
    chk("t2_pkt_count", 64'(tx_pkt_count), 64'(exp_pkts));

    // 3: tx_ready toggling; ready to owner mirrors it, beats intact; eop on last allowed beat.
    send_pkt(0, 4, 2'd1, 2'd0, 6);
    k = 0;
    while ((sb.size() != 0 || q0.size() != 0) && k < 40) begin
      tx_ready = (k % 2 == 0);
      cycle();
      if (obs_grant == 2'b01) begin
        chk("t3_ready0_mirror", 64'(obs_src_ready[0]), 64'(tx_ready));
        chk("t3_ready1_held",   64'(obs_src_ready[1]), 64'd0);
      end
      k++;
    end
    tx_ready = 1'b1;
    run_until_empty(20, "t3");
    chk("t3_pkt_count", 64'(tx_pkt_count), 64'(exp_pkts));
    chk("t3_no_trunc",  64'(trunc_count),  64'd0);

    // 4: 6-beat packet from source 1 is cut at 4 beats, the rest drained.
    drained = 0;
    send_pkt(1, 6, 2'd3, 2'd3, 7);
    k = 0;
    while ((sb.size() != 0 || q1.size() != 0) && k < 40) begin
      cycle();
      if (obs_drain) chk("t4_drain_grant", 64'(obs_grant), 64'b10);
      k++;
    end
    run_until_empty(20, "t4");
    chk("t4_drained",     64'(drained),      64'd2);
    chk("t4_trunc_count", 64'(trunc_count),  64'd1);
    chk("t4_pkt_count",   64'(tx_pkt_count), 64'(exp_pkts));

    // 5: only source 1 enabled; enabling source 0 mid-packet lets it win next.
    src_enable = 2'b10;
    send_pkt(1, 2, 2'd0, 2'd0, 8);
    send_pkt(0, 2, 2'd1, 2'd0, 9);
    send_pkt(1, 2, 2'd2, 2'd0, 10);
    cycle();
    cycle();
    chk("t5_grant_src1", 64'(obs_grant), 64'b10);
    src_enable = 2'b11;
    run_until_empty(30, "t5");
    chk("t5_pkt_count", 64'(tx_pkt_count), 64'(exp_pkts));

    // 6: source 0 wins, then reset hits beat 2 of a source 1 packet.
    send_pkt(0, 2, 2'd0, 2'd0, 11);
    run_until_empty(20, "t6a");
    send_pkt(1, 3, 2'd0, 2'd0, 12);
    cycle();
    cycle();
    chk("t6_pre_grant", 64'(obs_grant), 64'b10);
    drive_inputs();
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(tx_valid),     64'd0);
    chk("t6_rst_grant", 64'(grant),        64'd0);
    chk("t6_rst_ready", 64'(src_ready),    64'd0);
    chk("t6_rst_pkts",  64'(tx_pkt_count), 64'd0);
    @(posedge clk);
    @(negedge clk);
    q0.delete();
    q1.delete();
    sb.delete();
    exp_pkts = 0;
    rst      = 1'b0;
    send_pkt(0, 2, 2'd1, 2'd0, 13);
    send_pkt(1, 2, 2'd2, 2'd0, 14);
    cycle();
    cycle();
    chk("t6_post_grant", 64'(obs_grant), 64'b01);
    run_until_empty(20, "t6b");
    chk("t6_pkt_count", 64'(tx_pkt_count), 64'(exp_pkts));
    chk("t6_trunc",     64'(trunc_count),  64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
